// File: rtl/dcache_ctrl_nway.sv
// rtl/dcache_ctrl_nway.sv - N-way dcache miss/allocate controller with tree-PLRU victim and optional fill-first write-back
module dcache_ctrl_nway #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 16,
    parameter int WB_FIRST = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(NUM_SETS)-1:0] i_set_idx,
    input  logic [3:0]                  i_rmask,
    input  logic [3:0]                  i_wmask,
    input  logic                        i_hit,
    input  logic [NUM_WAYS-1:0]         i_hit_way,
    input  logic [NUM_WAYS-1:0]         i_way_valid,
    input  logic [NUM_WAYS-1:0]         i_way_dirty,
    input  logic [31:0]                 i_dfp_addr,
    output logic                        o_stall,
    output logic [$clog2(NUM_WAYS)-1:0] o_victim_way,
    output logic                        o_allocate_done,
    output logic                        o_write_hit,
    output logic                        o_write_hit_rec,
    output logic                        o_wb_buf_load,
    output logic                        o_dfp_read,
    output logic                        o_dfp_write,
    input  logic                        i_dfp_ready,
    input  logic [31:0]                 i_dfp_raddr,
    input  logic                        i_dfp_rvalid
);
    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int PB    = NUM_WAYS - 1;

    typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FILL_WAIT, S_DONE, S_DRAIN} state_t;

    state_t           r_state, w_next;
    logic [PB-1:0]    r_plru [NUM_SETS];
    logic [WAY_W-1:0] r_victim;
    logic [SET_W-1:0] r_miss_set;
    logic             r_wb_pending;
    logic             r_write_hit_rec;

    logic             w_req, w_hit_ok, w_miss_start, w_victim_dirty;
    logic [WAY_W-1:0] w_hit_idx, w_inv_idx, w_victim;

    // Heap-ordered tree: node n (1-based) has children 2n and 2n+1; bit 0 steers left.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PB-1:0] bits);
        int node;
        node = 1;
        for (int l = 0; l < WAY_W; l++) node = 2 * node + int'(bits[node-1]);
        return WAY_W'(node - NUM_WAYS);
    endfunction

    function automatic logic [PB-1:0] plru_touch(input logic [PB-1:0] bits, input logic [WAY_W-1:0] way);
        logic [PB-1:0] b;
        int node;
        b    = bits;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            b[node-1] = ~way[WAY_W-1-l];
            node      = 2 * node + int'(way[WAY_W-1-l]);
        end
        return b;
    endfunction

    always_comb begin
        w_hit_idx = '0;
        w_inv_idx = '0;
        for (int i = 0; i < NUM_WAYS; i++) if (i_hit_way[i]) w_hit_idx = WAY_W'(i);
        for (int i = NUM_WAYS - 1; i >= 0; i--) if (!i_way_valid[i]) w_inv_idx = WAY_W'(i);
    end

    assign w_req          = (|i_rmask) | (|i_wmask);
    assign w_victim       = (&i_way_valid) ? plru_victim(r_plru[i_set_idx]) : w_inv_idx;
    assign w_victim_dirty = i_way_valid[w_victim] & i_way_dirty[w_victim];
    assign w_hit_ok       = w_req & ~r_write_hit_rec & i_hit & (r_state == S_IDLE || r_state == S_DRAIN);

    always_comb begin
        w_next          = r_state;
        o_stall         = w_req;
        o_write_hit     = 1'b0;
        o_allocate_done = 1'b0;
        o_wb_buf_load   = 1'b0;
        o_dfp_read      = 1'b0;
        o_dfp_write     = 1'b0;
        w_miss_start    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_stall = w_req & (r_write_hit_rec | ~i_hit);
                if (w_hit_ok) begin
                    o_write_hit = |i_wmask;
                end else if (w_req && !i_hit) begin
                    w_miss_start = 1'b1;
                    if (w_victim_dirty && WB_FIRST != 0) begin
                        w_next = S_WB;
                    end else begin
                        o_wb_buf_load = w_victim_dirty;
                        w_next        = S_FILL;
                    end
                end
            end
            S_WB: begin
                o_dfp_write = 1'b1;
                if (i_dfp_ready) w_next = S_FILL;
            end
            S_FILL: begin
                o_dfp_read = 1'b1;
                if (i_dfp_ready) w_next = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (i_dfp_rvalid && i_dfp_raddr == i_dfp_addr) begin
                    o_allocate_done = 1'b1;
                    w_next          = S_DONE;
                end
            end
            S_DONE: w_next = r_wb_pending ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
                // Hits keep flowing while the parked victim drains; misses wait for IDLE.
                o_stall     = w_req & (r_write_hit_rec | ~i_hit);
                o_write_hit = w_hit_ok & (|i_wmask);
                o_dfp_write = 1'b1;
                if (i_dfp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_victim        <= '0;
            r_miss_set      <= '0;
            r_wb_pending    <= 1'b0;
            r_write_hit_rec <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) r_plru[s] <= '0;
        end else begin
            r_state         <= w_next;
            r_write_hit_rec <= o_write_hit;
            if (w_miss_start) begin
                r_victim   <= w_victim;
                r_miss_set <= i_set_idx;
            end
            if (o_wb_buf_load) r_wb_pending <= 1'b1;
            else if (r_state == S_DRAIN && i_dfp_ready) r_wb_pending <= 1'b0;
            if (w_hit_ok) r_plru[i_set_idx] <= plru_touch(r_plru[i_set_idx], w_hit_idx);
            else if (o_allocate_done) r_plru[r_miss_set] <= plru_touch(r_plru[r_miss_set], r_victim);
        end
    end

    assign o_victim_way    = r_victim;
    assign o_write_hit_rec = r_write_hit_rec;
endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// tb/tb_dcache_ctrl_nway.sv - directed self-checking bench for dcache_ctrl_nway (WB_FIRST=1 and WB_FIRST=0 instances)
module tb_dcache_ctrl_nway;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  set_idx, rmask, wmask, hit_way, way_valid, way_dirty;
    logic        hit, dfp_ready, dfp_rvalid;
    logic [31:0] dfp_addr, dfp_raddr;

    logic       s1_stall, s1_alloc, s1_wh, s1_whr, s1_wbl, s1_rd, s1_wr;
    logic [1:0] s1_victim;
    logic       s0_stall, s0_alloc, s0_wh, s0_whr, s0_wbl, s0_rd, s0_wr;
    logic [1:0] s0_victim;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dcache_ctrl_nway #(.NUM_WAYS(4), .NUM_SETS(16), .WB_FIRST(1)) u_wb1 (
        .clk(clk), .rst(rst), .i_set_idx(set_idx), .i_rmask(rmask), .i_wmask(wmask),
        .i_hit(hit), .i_hit_way(hit_way), .i_way_valid(way_valid), .i_way_dirty(way_dirty),
        .i_dfp_addr(dfp_addr), .o_stall(s1_stall), .o_victim_way(s1_victim),
        .o_allocate_done(s1_alloc), .o_write_hit(s1_wh), .o_write_hit_rec(s1_whr),
        .o_wb_buf_load(s1_wbl), .o_dfp_read(s1_rd), .o_dfp_write(s1_wr),
        .i_dfp_ready(dfp_ready), .i_dfp_raddr(dfp_raddr), .i_dfp_rvalid(dfp_rvalid)
    );

    dcache_ctrl_nway #(.NUM_WAYS(4), .NUM_SETS(16), .WB_FIRST(0)) u_wb0 (
        .clk(clk), .rst(rst), .i_set_idx(set_idx), .i_rmask(rmask), .i_wmask(wmask),
        .i_hit(hit), .i_hit_way(hit_way), .i_way_valid(way_valid), .i_way_dirty(way_dirty),
        .i_dfp_addr(dfp_addr), .o_stall(s0_stall), .o_victim_way(s0_victim),
        .o_allocate_done(s0_alloc), .o_write_hit(s0_wh), .o_write_hit_rec(s0_whr),
        .o_wb_buf_load(s0_wbl), .o_dfp_read(s0_rd), .o_dfp_write(s0_wr),
        .i_dfp_ready(dfp_ready), .i_dfp_raddr(dfp_raddr), .i_dfp_rvalid(dfp_rvalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rmask = '0; wmask = '0; hit = 1'b0; hit_way = '0;
        way_valid = '0; way_dirty = '0; dfp_ready = 1'b0; dfp_rvalid = 1'b0;
        dfp_raddr = '0; set_idx = '0; dfp_addr = 32'h100;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        cyc();
        #1;
        chk("rst_stall",  32'(s1_stall), 32'd0);
        chk("rst_victim", 32'(s1_victim), 32'd0);
        chk("rst_read",   32'(s1_rd), 32'd0);
        chk("rst_write",  32'(s1_wr), 32'd0);
        chk("rst_rec",    32'(s1_whr), 32'd0);
        chk("rst_wbload", 32'(s0_wbl), 32'd0);

        // read hit way2 set5
        set_idx = 4'd5; rmask = 4'hf; hit = 1'b1; hit_way = 4'b0100; way_valid = 4'hf; way_dirty = 4'h0;
        #1;
        chk("rhit_stall", 32'(s1_stall), 32'd0);
        chk("rhit_wh",    32'(s1_wh), 32'd0);
        chk("rhit_read",  32'(s1_rd), 32'd0);
        cyc();
        chk("rhit_plru5", 32'(u_wb1.r_plru[5]), 32'h4);

        // write hit way0 set5
        rmask = 4'h0; wmask = 4'hf; hit_way = 4'b0001;
        #1;
        chk("wh_n_wh",    32'(s1_wh), 32'd1);
        chk("wh_n_stall", 32'(s1_stall), 32'd0);
        cyc();
        chk("wh_n1_rec",   32'(s1_whr), 32'd1);
        chk("wh_n1_stall", 32'(s1_stall), 32'd1);
        chk("wh_n1_wh",    32'(s1_wh), 32'd0);
        cyc();
        wmask = 4'h0; hit = 1'b0; hit_way = 4'h0;
        #1;
        chk("wh_n2_rec",   32'(s1_whr), 32'd0);
        chk("wh_n2_stall", 32'(s1_stall), 32'd0);
        chk("wh_n2_wh",    32'(s1_wh), 32'd0);

        // clean read miss, full set5; PLRU after way2 then way0 points at way3
        rmask = 4'hf;
        #1;
        chk("miss_idle_stall", 32'(s1_stall), 32'd1);
        chk("miss_idle_read",  32'(s1_rd), 32'd0);
        cyc();
        chk("miss_victim", 32'(s1_victim), 32'd3);
        chk("miss_read",   32'(s1_rd), 32'd1);
        chk("miss_write",  32'(s1_wr), 32'd0);
        cyc();
        chk("miss_read_held", 32'(s1_rd), 32'd1);
        dfp_ready = 1'b1;
        #1;
        chk("miss_read_rdy", 32'(s1_rd), 32'd1);
        cyc();
        dfp_ready = 1'b0; dfp_rvalid = 1'b1; dfp_raddr = 32'h200;
        #1;
        chk("miss_stale_alloc", 32'(s1_alloc), 32'd0);
        chk("miss_wait_read",   32'(s1_rd), 32'd0);
        cyc();
        dfp_raddr = 32'h100;
        #1;
        chk("miss_alloc",     32'(s1_alloc), 32'd1);
        chk("miss_alloc_way", 32'(s1_victim), 32'd3);
        cyc();
        dfp_rvalid = 1'b0;
        #1;
        chk("miss_done_stall", 32'(s1_stall), 32'd1);
        chk("miss_done_alloc", 32'(s1_alloc), 32'd0);
        cyc();
        hit = 1'b1; hit_way = 4'b1000;
        #1;
        chk("miss_then_hit_stall", 32'(s1_stall), 32'd0);

        // WB_FIRST=1 dirty miss, ready delayed 3 cycles
        do_reset();
        set_idx = 4'd7; rmask = 4'hf; way_valid = 4'hf; way_dirty = 4'hf;
        #1;
        chk("wbf_idle_write", 32'(s1_wr), 32'd0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk("wbf_write_held", 32'(s1_wr), 32'd1);
            chk("wbf_no_read",    32'(s1_rd), 32'd0);
            cyc();
        end
        dfp_ready = 1'b1;
        #1;
        chk("wbf_write_rdy", 32'(s1_wr), 32'd1);
        cyc();
        dfp_ready = 1'b0;
        #1;
        chk("wbf_then_read",  32'(s1_rd), 32'd1);
        chk("wbf_then_write", 32'(s1_wr), 32'd0);

        // WB_FIRST=0 dirty miss: park victim, fill, drain
        do_reset();
        set_idx = 4'd7; rmask = 4'hf; way_valid = 4'hf; way_dirty = 4'hf;
        #1;
        chk("ff_wbload",     32'(s0_wbl), 32'd1);
        chk("ff_idle_write", 32'(s0_wr), 32'd0);
        cyc();
        chk("ff_wbload_once", 32'(s0_wbl), 32'd0);
        chk("ff_read",        32'(s0_rd), 32'd1);
        dfp_ready = 1'b1;
        cyc();
        dfp_ready = 1'b0; dfp_rvalid = 1'b1; dfp_raddr = 32'h100;
        #1;
        chk("ff_alloc",     32'(s0_alloc), 32'd1);
        chk("ff_alloc_way", 32'(s0_victim), 32'd0);
        cyc();
        dfp_rvalid = 1'b0;
        #1;
        chk("ff_done_write", 32'(s0_wr), 32'd0);
        chk("ff_done_stall", 32'(s0_stall), 32'd1);
        cyc();
        hit = 1'b1; hit_way = 4'b0001;
        #1;
        chk("ff_drain_write",     32'(s0_wr), 32'd1);
        chk("ff_drain_read",      32'(s0_rd), 32'd0);
        chk("ff_drain_hit_stall", 32'(s0_stall), 32'd0);
        cyc();
        hit = 1'b0; hit_way = 4'h0;
        #1;
        chk("ff_drain_miss_stall", 32'(s0_stall), 32'd1);
        dfp_ready = 1'b1;
        #1;
        chk("ff_drain_write_rdy", 32'(s0_wr), 32'd1);
        cyc();
        dfp_ready = 1'b0; way_dirty = 4'h0;
        #1;
        chk("ff_idle_after_write", 32'(s0_wr), 32'd0);
        chk("ff_idle_miss_stall",  32'(s0_stall), 32'd1);

        // four fills into an empty set take ways 0..3
        do_reset();
        set_idx = 4'd3; rmask = 4'hf;
        for (int i = 0; i < 4; i++) begin
            way_valid = 4'((1 << i) - 1);
            #1;
            cyc();
            chk("fill_victim", 32'(s1_victim), 32'(i));
            dfp_ready = 1'b1;
            cyc();
            dfp_ready = 1'b0; dfp_rvalid = 1'b1; dfp_raddr = 32'h100;
            #1;
            chk("fill_alloc", 32'(s1_alloc), 32'd1);
            cyc();
            dfp_rvalid = 1'b0;
            cyc();
        end
        way_valid = 4'hf;
        #1;
        cyc();
        chk("fill5_victim", 32'(s1_victim), 32'd0);
        dfp_ready = 1'b1;
        cyc();
        dfp_ready = 1'b0;
        #1;
        chk("fill5_wait_read", 32'(s1_rd), 32'd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0; rmask = 4'h0; dfp_rvalid = 1'b1; dfp_raddr = 32'h100;
        #1;
        chk("rstmid_read",   32'(s1_rd), 32'd0);
        chk("rstmid_alloc",  32'(s1_alloc), 32'd0);
        chk("rstmid_victim", 32'(s1_victim), 32'd0);
        dfp_rvalid = 1'b0; rmask = 4'hf; hit = 1'b1; hit_way = 4'b0001;
        #1;
        chk("rstmid_hit_stall", 32'(s1_stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
